// File: rtl/up_down_counter_pkg.sv
// ---------------------------------------------------------------------------
// up_down_counter_pkg
//   Shared constants for the up/down counter leaf block.
//   No ports; imported by up_down_counter.
// ---------------------------------------------------------------------------
package up_down_counter_pkg;

  // Default counter width. Instances may override it.
  localparam int UDC_DEFAULT_WIDTH = 4;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter.sv
// ---------------------------------------------------------------------------
// up_down_counter
//   Free-running binary up/down counter. It moves by one on every rising edge
//   of clk. The direction is chosen per cycle, and the count wraps silently
//   modulo 2^WIDTH.
//
// Parameters
//   WIDTH      counter width in bits (>= 1)
//   RESET_VAL  value loaded while reset is low
//
// Ports
//   clk      input   1      system clock, rising-edge active
//   reset    input   1      synchronous reset, active low (0 = reset)
//   up_down  input   1      1 = increment, 0 = decrement
//   counter  output  WIDTH  current count, driven straight from the register
// ---------------------------------------------------------------------------
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int               WIDTH     = UDC_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_down,
  output logic [WIDTH-1:0] counter
);

  logic [WIDTH-1:0] counter_q;
  logic [WIDTH-1:0] counter_d;

  // Next-state value: there is no hold state. Any carry or borrow falls off
  // the top, and that is what produces the silent wrap-around.
  always_comb begin
    counter_d = counter_q;
    if (up_down) begin
      counter_d = counter_q + WIDTH'(1);
    end else begin
      counter_d = counter_q - WIDTH'(1);
    end
  end

  // Reset is sampled only on the clock edge and takes priority over direction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      counter_q <= RESET_VAL;
    end else begin
      counter_q <= counter_d;
    end
  end

  assign counter = counter_q;

`ifndef SYNTHESIS
  // Before the first reset the count is undefined. This flag holds off the
  // step check until the register has taken a known value.
  bit seen_reset_q = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      seen_reset_q <= 1'b1;
    end
  end

  property p_reset_loads;
    @(posedge clk) !reset |=> (counter == RESET_VAL);
  endproperty

  property p_step_by_one;
    @(posedge clk) disable iff (!seen_reset_q)
      reset |=> (counter == ($past(up_down) ? $past(counter) + WIDTH'(1)
                                            : $past(counter) - WIDTH'(1)));
  endproperty

  a_reset_loads:  assert property (p_reset_loads);
  a_step_by_one:  assert property (p_step_by_one);
`endif

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// ---------------------------------------------------------------------------
// tb_up_down_counter
//   Directed and randomized stimulus for up_down_counter. Expected counts come
//   from an integer reference model that works modulo 2^W.
// ---------------------------------------------------------------------------
module tb_up_down_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;
  localparam int RV  = 0;

  logic         clk = 1'b0;
  logic         reset;
  logic         up_down;
  logic [W-1:0] counter;

  int vecs  = 0;
  int errs  = 0;
  int model = 0;
  bit known = 1'b0;

  always #5 clk = ~clk;

  up_down_counter #(
    .WIDTH    (W),
    .RESET_VAL(W'(RV))
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .up_down(up_down),
    .counter(counter)
  );

  task automatic check(input string tag, input int exp);
    logic [W-1:0] e;
    e = W'(exp);
    vecs++;
    assert (counter === e) else begin
      errs++;
      $error("FAIL %s: counter=%h expected=%h", tag, counter, e);
    end
  endtask

  // Drive the inputs on the falling edge. The count must not move until the
  // next rising edge, and after that edge it must match the model.
  task automatic step(input logic r, input logic ud, input string tag);
    @(negedge clk);
    reset   = r;
    up_down = ud;
    #1;
    if (known) check({tag, "_nocomb"}, model);
    @(posedge clk);
    #1;
    if (!r) begin
      model = RV;
      known = 1'b1;
    end else if (ud) begin
      model = (model + 1) % MOD;
    end else begin
      model = (model + MOD - 1) % MOD;
    end
    check(tag, model);
    $display("step %-8s reset=%0b up_down=%0b counter=%h model=%h",
             tag, r, ud, counter, W'(model));
  endtask

  initial begin
    reset   = 1'b0;
    up_down = 1'b0;

    // Hold reset for two edges with up_down low. The count stays at the reset value.
    step(1'b0, 1'b0, "reset");
    step(1'b0, 1'b0, "reset");

    // Count down from 0. Expect F,E,...,0,F, which covers the down wrap.
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, "down");

    // Return to 0, then count up 16 times. Expect 1..F,0, which covers the up wrap.
    step(1'b0, 1'b0, "reset");
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, "up");

    // Move to 5, then flip direction every cycle, going up first: 6,5,6,5,...
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "to5");
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0), "flip");

    // Move to A. Apply reset for one edge with up_down high to get 0, then 1 on release.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "toA");
    step(1'b0, 1'b1, "midrst");
    step(1'b1, 1'b1, "release");

    // Long run: 200 ns of counting down, then counting up.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "longdn");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, "longup");

    // Random direction with occasional reset pulses.
    for (int i = 0; i < 80; i++)
      step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_up_down_counter
